// File: rtl/coreuart_fifo_pkg.sv
// Shared constants, types and helpers for the CoreUART synchronous FIFO.
package coreuart_fifo_pkg;

    localparam int FIFO_MIN_DEPTH = 4;
    localparam int FIFO_MAX_DEPTH = 4096;

    typedef struct packed {
        logic ovf;
        logic udf;
    } fifo_err_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/coreuart_fifo_sync_if.sv
// Data, handshake, threshold and status signals between the FIFO and its user.
interface coreuart_fifo_sync_if
    import coreuart_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] DI;
    logic             WE;
    logic             RE;
    logic [AW:0]      AFULL_LEVEL;
    logic [AW:0]      AEMPTY_LEVEL;
    logic             CLR_ERR;
    logic [WIDTH-1:0] DO;
    logic             FULL;
    logic             EMPTY;
    logic             AFULL;
    logic             AEMPTY;
    logic [AW:0]      COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output DI, WE, RE, AFULL_LEVEL, AEMPTY_LEVEL, CLR_ERR,
        input  DO, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  DI, WE, RE, AFULL_LEVEL, AEMPTY_LEVEL, CLR_ERR,
        output DO, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/coreuart_fifo_ram.sv
// Simple-dual-port RAM with registered read; storage is never reset, only the read register.
module coreuart_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/coreuart_fifo_sync.sv
// Parametrised single-clock FIFO with thresholds, occupancy count and sticky errors.
// Define COREUART_FIFO_FWFT_EN for first-word-fall-through output; default is standard mode.
module coreuart_fifo_sync
    import coreuart_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input logic                 CLOCK,
    input logic                 RESET,
    coreuart_fifo_sync_if.slave bus
);

    localparam int          AW       = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    generate
        if (DEPTH < FIFO_MIN_DEPTH || DEPTH > FIFO_MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0 ||
            WIDTH < 1 || WIDTH > 32) begin : g_bad_param
            $error("coreuart_fifo_sync: unsupported WIDTH/DEPTH");
        end
    endgenerate

    logic [AW:0]      wptr, rptr, count, count_nxt;
    logic             full_r, afull_r, aempty_r, empty;
    logic             wr_acc, rd_acc, rptr_inc, ram_re;
    logic [WIDTH-1:0] ram_rdata;
    fifo_err_t        err;

    assign wr_acc = bus.WE && !full_r && !RESET;

`ifdef COREUART_FIFO_FWFT_EN
    // The RAM read register doubles as the head-word register; it refills whenever it is free.
    logic        dout_vld;
    logic [AW:0] mem_cnt;

    assign mem_cnt  = wptr - rptr;
    assign empty    = !dout_vld;
    assign rd_acc   = bus.RE && dout_vld;
    assign rptr_inc = (mem_cnt != '0) && (!dout_vld || rd_acc) && !RESET;
    assign ram_re   = rptr_inc;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            dout_vld <= 1'b0;
        end else if (rptr_inc) begin
            dout_vld <= 1'b1;
        end else if (rd_acc) begin
            dout_vld <= 1'b0;
        end
    end
`else
    logic empty_r;

    assign empty    = empty_r;
    assign rd_acc   = bus.RE && !empty_r;
    assign rptr_inc = rd_acc && !RESET;
    assign ram_re   = rptr_inc;

    always_ff @(posedge CLOCK) begin
        empty_r <= (count_nxt == '0);
    end
`endif

    always_comb begin
        count_nxt = count;
        if (RESET) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
        end
    end

    // Flags follow next-state COUNT so they move on the same edge as COUNT.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wptr <= '0;
            rptr <= '0;
            err  <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rptr_inc) begin
                rptr <= rptr + 1'b1;
            end
            err.ovf <= (bus.WE && full_r) || (err.ovf && !bus.CLR_ERR);
            err.udf <= (bus.RE && empty) || (err.udf && !bus.CLR_ERR);
        end
        count    <= count_nxt;
        full_r   <= (count_nxt == FULL_CNT);
        afull_r  <= (count_nxt >= bus.AFULL_LEVEL);
        aempty_r <= (count_nxt <= bus.AEMPTY_LEVEL);
    end

    coreuart_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (CLOCK),
        .rst   (RESET),
        .we    (wr_acc),
        .waddr (wptr[AW-1:0]),
        .wdata (bus.DI),
        .re    (ram_re),
        .raddr (rptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign bus.DO        = ram_rdata;
    assign bus.FULL      = full_r;
    assign bus.EMPTY     = empty;
    assign bus.AFULL     = afull_r;
    assign bus.AEMPTY    = aempty_r;
    assign bus.COUNT     = count;
    assign bus.OVERFLOW  = err.ovf;
    assign bus.UNDERFLOW = err.udf;

endmodule
